// File: rtl/pc_update_sequencer.sv
// pc_update_sequencer
//   Multicycle controller that owns the PC-source mux select and the PC/EPC
//   write enables. It turns one-cycle requests from the main control FSM into
//   timed select/write pulses for sequential fetch, branches, jumps, RTE and
//   the multi-cycle exception entry (save EPC, read vector byte, load PC).
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   fetch_req           request PC <= PC+4 (ALU result)
//   op_valid, op[2:0]   control-flow request: 1 BEQ 2 BNE 3 BLE 4 BGT
//                       5 J/JAL 6 JR 7 RTE (0 ignored)
//   alu_zero, alu_gt    branch compare flags, captured when the request is taken
//   exc_opcode/div0/ovf exception requests (priority opcode > div0 > ovf)
//   pc_source[2:0]      PC mux select: 0 AluResult 1 AluOut 2 Jump 3 MDR
//                       4 EPC 5 exception vector
//   pc_write, epc_write PC / EPC load enables
//   alu_sub4            ALU computes PC-4 for the EPC save
//   mem_read, vec_addr  vector byte read strobe and address
//   exc_cause[1:0]      last exception cause (0 none 1 opcode 2 div0 3 ovf)
//   busy, done          sequencer not idle / sequence-complete pulse
module pc_update_sequencer #(
  parameter int unsigned MEM_LAT    = 2,
  parameter logic [7:0]  VEC_OPCODE = 8'd253,
  parameter logic [7:0]  VEC_OVF    = 8'd254,
  parameter logic [7:0]  VEC_DIV0   = 8'd255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fetch_req,
  input  logic       op_valid,
  input  logic [2:0] op,
  input  logic       alu_zero,
  input  logic       alu_gt,
  input  logic       exc_opcode,
  input  logic       exc_div0,
  input  logic       exc_ovf,
  output logic [2:0] pc_source,
  output logic       pc_write,
  output logic       epc_write,
  output logic       alu_sub4,
  output logic       mem_read,
  output logic [7:0] vec_addr,
  output logic [1:0] exc_cause,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    EXC_EPC,
    EXC_RD,
    EXC_WAIT,
    EXC_LOAD
  } state_t;

  // EXC_WAIT lasts MEM_LAT-1 cycles; the counter is loaded with MEM_LAT-2.
  localparam logic [2:0] WAIT_INIT = (MEM_LAT > 1) ? 3'(MEM_LAT - 2) : 3'd0;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] pc_source_q, pc_source_d;
  logic       pc_write_q, pc_write_d;
  logic       epc_write_q, epc_write_d;
  logic       alu_sub4_q, alu_sub4_d;
  logic       mem_read_q, mem_read_d;
  logic [7:0] vec_addr_q, vec_addr_d;
  logic [1:0] exc_cause_q, exc_cause_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  function automatic logic [7:0] vec_for(input logic [1:0] cause);
    case (cause)
      2'd1:    vec_for = VEC_OPCODE;
      2'd2:    vec_for = VEC_DIV0;
      2'd3:    vec_for = VEC_OVF;
      default: vec_for = '0;
    endcase
  endfunction

  // Outputs are registered, so each branch computes the values that will be
  // visible while the FSM sits in state_d.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_source_d = '0;
    pc_write_d  = 1'b0;
    epc_write_d = 1'b0;
    alu_sub4_d  = 1'b0;
    mem_read_d  = 1'b0;
    vec_addr_d  = '0;
    exc_cause_d = exc_cause_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (exc_opcode || exc_div0 || exc_ovf) begin
          state_d     = EXC_EPC;
          epc_write_d = 1'b1;
          alu_sub4_d  = 1'b1;
          busy_d      = 1'b1;
          if (exc_opcode)    exc_cause_d = 2'd1;
          else if (exc_div0) exc_cause_d = 2'd2;
          else               exc_cause_d = 2'd3;
        end else if (op_valid) begin
          // op=0 suppresses fetch_req as well: no action at all.
          if (op != 3'd0) begin
            state_d = ISSUE;
            busy_d  = 1'b1;
            done_d  = 1'b1;
            case (op)
              3'd1: begin pc_source_d = 3'd1; pc_write_d = alu_zero;  end
              3'd2: begin pc_source_d = 3'd1; pc_write_d = ~alu_zero; end
              3'd3: begin pc_source_d = 3'd1; pc_write_d = ~alu_gt;   end
              3'd4: begin pc_source_d = 3'd1; pc_write_d = alu_gt;    end
              3'd5: begin pc_source_d = 3'd2; pc_write_d = 1'b1;      end
              3'd6: begin pc_source_d = 3'd0; pc_write_d = 1'b1;      end
              default: begin pc_source_d = 3'd4; pc_write_d = 1'b1;   end
            endcase
          end
        end else if (fetch_req) begin
          state_d    = ISSUE;
          busy_d     = 1'b1;
          done_d     = 1'b1;
          pc_write_d = 1'b1;
        end
      end

      ISSUE: state_d = IDLE;

      EXC_EPC: begin
        state_d    = EXC_RD;
        mem_read_d = 1'b1;
        vec_addr_d = vec_for(exc_cause_q);
        busy_d     = 1'b1;
      end

      EXC_RD: begin
        vec_addr_d = vec_addr_q;
        busy_d     = 1'b1;
        if (MEM_LAT == 1) begin
          state_d     = EXC_LOAD;
          pc_source_d = 3'd5;
          pc_write_d  = 1'b1;
          done_d      = 1'b1;
        end else begin
          state_d = EXC_WAIT;
          cnt_d   = WAIT_INIT;
        end
      end

      EXC_WAIT: begin
        vec_addr_d = vec_addr_q;
        busy_d     = 1'b1;
        if (cnt_q == 3'd0) begin
          state_d     = EXC_LOAD;
          pc_source_d = 3'd5;
          pc_write_d  = 1'b1;
          done_d      = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      EXC_LOAD: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pc_source_q <= '0;
      pc_write_q  <= 1'b0;
      epc_write_q <= 1'b0;
      alu_sub4_q  <= 1'b0;
      mem_read_q  <= 1'b0;
      vec_addr_q  <= '0;
      exc_cause_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc_source_q <= pc_source_d;
      pc_write_q  <= pc_write_d;
      epc_write_q <= epc_write_d;
      alu_sub4_q  <= alu_sub4_d;
      mem_read_q  <= mem_read_d;
      vec_addr_q  <= vec_addr_d;
      exc_cause_q <= exc_cause_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign pc_source = pc_source_q;
  assign pc_write  = pc_write_q;
  assign epc_write = epc_write_q;
  assign alu_sub4  = alu_sub4_q;
  assign mem_read  = mem_read_q;
  assign vec_addr  = vec_addr_q;
  assign exc_cause = exc_cause_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pc_update_sequencer.sv
module tb_pc_update_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       fetch_req = 1'b0, op_valid = 1'b0, alu_zero = 1'b0, alu_gt = 1'b0;
  logic [2:0] op = '0;
  logic       exc_opcode = 1'b0, exc_div0 = 1'b0, exc_ovf = 1'b0;
  logic       exc_b = 1'b0, fetch_b = 1'b0, zero_b = 1'b0;
  logic [2:0] op_b = '0;

  logic [2:0] a_ps, b_ps;
  logic       a_pw, a_ew, a_sub, a_mr, a_busy, a_done;
  logic       b_pw, b_ew, b_sub, b_mr, b_busy, b_done;
  logic [7:0] a_va, b_va;
  logic [1:0] a_ec, b_ec;

  pc_update_sequencer #(.MEM_LAT(2)) dut_a (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .op_valid(op_valid), .op(op),
    .alu_zero(alu_zero), .alu_gt(alu_gt), .exc_opcode(exc_opcode), .exc_div0(exc_div0),
    .exc_ovf(exc_ovf), .pc_source(a_ps), .pc_write(a_pw), .epc_write(a_ew),
    .alu_sub4(a_sub), .mem_read(a_mr), .vec_addr(a_va), .exc_cause(a_ec),
    .busy(a_busy), .done(a_done));

  pc_update_sequencer #(.MEM_LAT(1)) dut_b (
    .clk(clk), .reset(reset), .fetch_req(fetch_b), .op_valid(zero_b), .op(op_b),
    .alu_zero(zero_b), .alu_gt(zero_b), .exc_opcode(exc_b), .exc_div0(zero_b),
    .exc_ovf(zero_b), .pc_source(b_ps), .pc_write(b_pw), .epc_write(b_ew),
    .alu_sub4(b_sub), .mem_read(b_mr), .vec_addr(b_va), .exc_cause(b_ec),
    .busy(b_busy), .done(b_done));

  // Packed view: {pc_source, pc_write, epc_write, alu_sub4, mem_read, vec_addr, exc_cause, busy, done}
  logic [18:0] oa, ob;
  assign oa = {a_ps, a_pw, a_ew, a_sub, a_mr, a_va, a_ec, a_busy, a_done};
  assign ob = {b_ps, b_pw, b_ew, b_sub, b_mr, b_va, b_ec, b_busy, b_done};

  int checks = 0;
  int errors = 0;

  function automatic logic [18:0] pk(input logic [2:0] ps, input logic pw, input logic ew,
                                     input logic sub, input logic mr, input logic [7:0] va,
                                     input logic [1:0] ec, input logic bz, input logic dn);
    pk = {ps, pw, ew, sub, mr, va, ec, bz, dn};
  endfunction

  task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One control-flow request: sample, check ISSUE, check return to idle.
  task automatic do_op(input string tag, input logic [2:0] o, input logic z, input logic g,
                       input logic [2:0] eps, input logic epw);
    op_valid = 1'b1; op = o; alu_zero = z; alu_gt = g;
    tick();
    op_valid = 1'b0; op = '0; alu_zero = ~z; alu_gt = ~g;
    chk(tag, oa, pk(eps, epw, 0, 0, 0, 8'd0, 2'd0, 1, 1));
    tick();
    chk({tag, "_idle"}, oa, pk(0, 0, 0, 0, 0, 8'd0, 2'd0, 0, 0));
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    chk("reset_a", oa, '0);
    chk("reset_b", ob, '0);

    // Sequential fetch; a fetch_req held into ISSUE is not queued.
    fetch_req = 1'b1;
    tick();
    chk("fetch_issue", oa, pk(0, 1, 0, 0, 0, 8'd0, 2'd0, 1, 1));
    tick();
    fetch_req = 1'b0;
    chk("fetch_idle", oa, '0);

    do_op("beq_taken",  3'd1, 1, 0, 3'd1, 1);
    do_op("beq_not",    3'd1, 0, 0, 3'd1, 0);
    do_op("bgt_taken",  3'd4, 0, 1, 3'd1, 1);
    do_op("bgt_not",    3'd4, 0, 0, 3'd1, 0);
    do_op("bne_taken",  3'd2, 0, 0, 3'd1, 1);
    do_op("ble_not",    3'd3, 0, 1, 3'd1, 0);
    do_op("rte",        3'd7, 0, 0, 3'd4, 1);
    do_op("jump",       3'd5, 0, 0, 3'd2, 1);
    do_op("jr",         3'd6, 0, 0, 3'd0, 1);

    // op=0 with op_valid suppresses even a simultaneous fetch_req.
    op_valid = 1'b1; op = 3'd0; fetch_req = 1'b1;
    tick();
    op_valid = 1'b0; fetch_req = 1'b0;
    chk("op0_ignored", oa, '0);

    // div0+ovf together with op/fetch: exception wins, div0 beats ovf.
    exc_div0 = 1'b1; exc_ovf = 1'b1; op_valid = 1'b1; op = 3'd5; fetch_req = 1'b1;
    tick();
    exc_div0 = 1'b0; exc_ovf = 1'b0; op_valid = 1'b0; op = '0;
    exc_opcode = 1'b1;
    chk("exc_epc", oa, pk(0, 0, 1, 1, 0, 8'd0, 2'd2, 1, 0));
    tick();
    chk("exc_rd", oa, pk(0, 0, 0, 0, 1, 8'd255, 2'd2, 1, 0));
    tick();
    chk("exc_wait", oa, pk(0, 0, 0, 0, 0, 8'd255, 2'd2, 1, 0));
    tick();
    chk("exc_load", oa, pk(5, 1, 0, 0, 0, 8'd255, 2'd2, 1, 1));
    tick();
    exc_opcode = 1'b0; fetch_req = 1'b0;
    chk("exc_idle_cause_held", oa, pk(0, 0, 0, 0, 0, 8'd0, 2'd2, 0, 0));

    // Overflow alone selects its own vector.
    exc_ovf = 1'b1;
    tick();
    exc_ovf = 1'b0;
    chk("ovf_epc", oa, pk(0, 0, 1, 1, 0, 8'd0, 2'd3, 1, 0));
    tick();
    chk("ovf_rd", oa, pk(0, 0, 0, 0, 1, 8'd254, 2'd3, 1, 0));
    tick(); tick(); tick();
    chk("ovf_idle", oa, pk(0, 0, 0, 0, 0, 8'd0, 2'd3, 0, 0));

    // MEM_LAT=1 instance: no wait state, pc_write at +3.
    exc_b = 1'b1;
    tick();
    exc_b = 1'b0;
    chk("lat1_epc", ob, pk(0, 0, 1, 1, 0, 8'd0, 2'd1, 1, 0));
    tick();
    chk("lat1_rd", ob, pk(0, 0, 0, 0, 1, 8'd253, 2'd1, 1, 0));
    tick();
    chk("lat1_load", ob, pk(5, 1, 0, 0, 0, 8'd253, 2'd1, 1, 1));
    tick();
    chk("lat1_idle", ob, pk(0, 0, 0, 0, 0, 8'd0, 2'd1, 0, 0));

    // Reset during EXC_WAIT aborts without any further write pulse.
    exc_opcode = 1'b1;
    tick();
    exc_opcode = 1'b0;
    tick();
    tick();
    chk("abort_in_wait", oa, pk(0, 0, 0, 0, 0, 8'd253, 2'd1, 1, 0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_reset", oa, '0);
    tick();
    chk("abort_no_load", oa, '0);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("post_abort_fetch", oa, pk(0, 1, 0, 0, 0, 8'd0, 2'd0, 1, 1));
    tick();
    chk("post_abort_idle", oa, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $fatal(1, "FAIL timeout: simulation did not finish");
  end

endmodule
